mv_systolic_engine: RTL and testbench

- Parametrised DIM x DIM matrix-vector multiplier built as a skewed linear systolic chain of DIM multiply-accumulate PEs, one PE per matrix row.
- Generalises the fixed 4x4 8-bit engine in three ways:
  - Any DIM and WIDTH.
  - Full-precision accumulators.
  - Runtime signed/unsigned mode and a start/ready/done handshake.
- Sits between the operand buffers and the result writeback in the compute datapath.

---
 rtl/mv_systolic_engine.sv | 173 +++++++++++++++++
 tb/tb_mv_systolic_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_systolic_engine.sv
// DIM x DIM matrix-vector multiplier: a skewed linear chain of DIM multiply-accumulate PEs,
// one per matrix row, with the vector element forwarded PE to PE through one register each.
module mv_systolic_engine #(
    parameter int DIM       = 4,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(DIM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [DIM*DIM*WIDTH-1:0]   mat,
    input  logic [DIM*WIDTH-1:0]       vec,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [DIM*ACC_WIDTH-1:0]   mv
);

    localparam int SW = $clog2(2*DIM);
    localparam logic [SW-1:0] LAST_STEP = SW'(2*DIM-2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    // Product sized so that both the unsigned and the signed extreme fit, then extended to the accumulator.
    function automatic logic signed [ACC_WIDTH-1:0] mac_term(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sm
    );
        logic signed [WIDTH:0]     a_ext;
        logic signed [WIDTH:0]     b_ext;
        logic signed [2*WIDTH+1:0] prod;
        a_ext = $signed({sm & a[WIDTH-1], a});
        b_ext = $signed({sm & b[WIDTH-1], b});
        prod  = (2*WIDTH+2)'(a_ext) * (2*WIDTH+2)'(b_ext);
        return ACC_WIDTH'(prod);
    endfunction

    state_e                         state_q, state_d;
    logic [SW-1:0]                  step_q, step_d;
    logic                           sm_q, sm_d;
    logic [WIDTH-1:0]               mat_q [DIM][DIM];
    logic [WIDTH-1:0]               mat_d [DIM][DIM];
    logic [WIDTH-1:0]               vec_q [DIM];
    logic [WIDTH-1:0]               vec_d [DIM];
    logic [WIDTH-1:0]               fwd_q [DIM-1];
    logic [WIDTH-1:0]               fwd_d [DIM-1];
    logic signed [ACC_WIDTH-1:0]    acc_q [DIM];
    logic signed [ACC_WIDTH-1:0]    acc_d [DIM];
    logic [DIM*ACC_WIDTH-1:0]       mv_q, mv_d;

    logic [WIDTH-1:0]               mat_in_s [DIM][DIM];
    logic [WIDTH-1:0]               vec_in_s [DIM];
    logic [WIDTH-1:0]               x_s [DIM];
    logic                           accept_s;

    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mat_in_s[r][c] = mat[(r*DIM+c)*WIDTH +: WIDTH];
            end
            vec_in_s[r] = vec[r*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        sm_d     = sm_q;
        mat_d    = mat_q;
        vec_d    = vec_q;
        fwd_d    = fwd_q;
        acc_d    = acc_q;
        mv_d     = mv_q;
        accept_s = start && (state_q != RUN);

        // PE0 is fed directly from the captured vector; later PEs see the forwarded copy.
        x_s[0] = '0;
        for (int k = 0; k < DIM; k++) begin
            if (step_q == SW'(k)) begin
                x_s[0] = vec_q[k];
            end
        end
        for (int r = 1; r < DIM; r++) begin
            x_s[r] = fwd_q[r-1];
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step_d   = step_q + SW'(1);
                fwd_d[0] = x_s[0];
                for (int r = 1; r < DIM-1; r++) begin
                    fwd_d[r] = fwd_q[r-1];
                end
                // PE r holds vec[k] at step k+r; outside that window it holds its sum.
                for (int r = 0; r < DIM; r++) begin
                    for (int k = 0; k < DIM; k++) begin
                        if (int'(step_q) == r + k) begin
                            acc_d[r] = acc_q[r] + mac_term(mat_q[r][k], x_s[r], sm_q);
                        end
                    end
                end
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                    for (int r = 0; r < DIM; r++) begin
                        mv_d[r*ACC_WIDTH +: ACC_WIDTH] = acc_d[r];
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_s) begin
            sm_d   = signed_mode;
            mat_d  = mat_in_s;
            vec_d  = vec_in_s;
            step_d = '0;
            for (int r = 0; r < DIM; r++) begin
                acc_d[r] = '0;
            end
            for (int r = 0; r < DIM-1; r++) begin
                fwd_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            sm_q    <= 1'b0;
            mat_q   <= '{default: '0};
            vec_q   <= '{default: '0};
            fwd_q   <= '{default: '0};
            acc_q   <= '{default: '0};
            mv_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sm_q    <= sm_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
            fwd_q   <= fwd_d;
            acc_q   <= acc_d;
            mv_q    <= mv_d;
        end
    end

    assign ready = (state_q != RUN);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign mv    = mv_q;

endmodule

// File: tb/tb_mv_systolic_engine.sv
// Bench for mv_systolic_engine: a 4x4x8 instance with directed vectors and an 8x8x4 instance
// with random operands, both compared every cycle against a sum-of-products reference.
module tb_mv_systolic_engine;

    localparam int ACC_A = 18;
    localparam int ACC_B = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               start_a = 1'b0, sm_a = 1'b0;
    logic [127:0]       mat_a = '0;
    logic [31:0]        vec_a = '0;
    logic               ready_a, busy_a, done_a;
    logic [4*ACC_A-1:0] mv_a;

    logic               start_b = 1'b0, sm_b = 1'b0;
    logic [255:0]       mat_b = '0;
    logic [31:0]        vec_b = '0;
    logic               ready_b, busy_b, done_b;
    logic [8*ACC_B-1:0] mv_b;

    mv_systolic_engine u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .signed_mode(sm_a), .mat(mat_a), .vec(vec_a),
        .ready(ready_a), .busy(busy_a), .done(done_a), .mv(mv_a)
    );

    mv_systolic_engine #(.DIM(8), .WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .signed_mode(sm_b), .mat(mat_b), .vec(vec_b),
        .ready(ready_b), .busy(busy_b), .done(done_b), .mv(mv_b)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Row r of the matrix-vector product, as a plain integer sum.
    function automatic longint ref_row(input logic [255:0] m, input logic [31:0] v,
                                       input int dim, input int w, input int r, input bit sm);
        longint s = 0;
        longint a, b;
        longint mask = (longint'(1) << w) - 1;
        for (int c = 0; c < dim; c++) begin
            a = longint'(m >> ((r*dim+c)*w)) & mask;
            b = longint'(v >> (c*w)) & mask;
            if (sm && a[w-1]) a -= (longint'(1) << w);
            if (sm && b[w-1]) b -= (longint'(1) << w);
            s += a * b;
        end
        return s;
    endfunction

    // Expected behaviour: busy for 2*DIM-1 cycles after an accepted start, then done with the product.
    bit busy_ma, done_ma;
    int left_ma;
    logic [4*ACC_A-1:0] pend_ma, mv_ma;
    always @(posedge clk) begin
        if (rst) begin
            busy_ma = 1'b0; done_ma = 1'b0; left_ma = 0; mv_ma = '0;
        end else if (busy_ma) begin
            left_ma--;
            if (left_ma == 0) begin
                busy_ma = 1'b0; done_ma = 1'b1; mv_ma = pend_ma;
            end
        end else begin
            done_ma = 1'b0;
            if (start_a) begin
                busy_ma = 1'b1; left_ma = 2*4-1;
                for (int r = 0; r < 4; r++) pend_ma[r*ACC_A +: ACC_A] = ACC_A'(ref_row(mat_a, vec_a, 4, 8, r, sm_a));
            end
        end
    end

    bit busy_mb, done_mb;
    int left_mb;
    logic [8*ACC_B-1:0] pend_mb, mv_mb;
    always @(posedge clk) begin
        if (rst) begin
            busy_mb = 1'b0; done_mb = 1'b0; left_mb = 0; mv_mb = '0;
        end else if (busy_mb) begin
            left_mb--;
            if (left_mb == 0) begin
                busy_mb = 1'b0; done_mb = 1'b1; mv_mb = pend_mb;
            end
        end else begin
            done_mb = 1'b0;
            if (start_b) begin
                busy_mb = 1'b1; left_mb = 2*8-1;
                for (int r = 0; r < 8; r++) pend_mb[r*ACC_B +: ACC_B] = ACC_B'(ref_row(mat_b, vec_b, 8, 4, r, sm_b));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_a", ready_a, !busy_ma);
            chk("busy_a", busy_a, busy_ma);
            chk("done_a", done_a, done_ma);
            chk("mv_a", mv_a, mv_ma);
            chk("ready_b", ready_b, !busy_mb);
            chk("busy_b", busy_b, busy_mb);
            chk("done_b", done_b, done_mb);
            chk("mv_b", mv_b, mv_mb);
        end
    end

    task automatic go_a(input logic [127:0] m, input logic [31:0] v, input logic s);
        mat_a = m; vec_a = v; sm_a = s; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic go_b();
        for (int w = 0; w < 8; w++) mat_b[w*32 +: 32] = $urandom();
        vec_b = $urandom();
        sm_b = 1'($urandom_range(0, 1));
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    // Edges counted from the accepting edge (which counts as 1) until done is seen.
    task automatic wait_done_a(output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (!done_a && lat < 40) begin
            if (busy_a) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done_a) chk("timeout_a", done_a, 1'b1);
    endtask

    task automatic wait_done_b(output int lat);
        lat = 1;
        while (!done_b && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done_b) chk("timeout_b", done_b, 1'b1);
    endtask

    logic [127:0] m_ident, m_max, m_80, m_row0;
    logic [31:0]  v_4321, v_max, v_80, v_ones;
    int lat, bcnt, steps;
    bit saw_done;

    initial begin
        m_ident = '0;
        for (int r = 0; r < 4; r++) m_ident[(r*4+r)*8 +: 8] = 8'd1;
        m_max  = {16{8'hFF}};
        m_80   = {16{8'h80}};
        m_row0 = {96'd0, {4{8'hFF}}};
        v_4321 = {8'd4, 8'd3, 8'd2, 8'd1};
        v_max  = {4{8'hFF}};
        v_80   = {4{8'h80}};
        v_ones = {4{8'h01}};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready_a, 1'b1);
        chk("reset_busy", busy_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        chk("reset_mv", mv_a, '0);
        rst = 1'b0;
        chk_en = 1'b1;

        go_a(m_ident, v_4321, 1'b0);
        wait_done_a(lat, bcnt);
        chk("ident_mv", mv_a, {18'd4, 18'd3, 18'd2, 18'd1});
        chk("ident_model", mv_ma, {18'd4, 18'd3, 18'd2, 18'd1});
        chk("ident_latency", lat, 8);
        chk("ident_busy_cycles", bcnt, 7);
        @(posedge clk); #1;
        chk("done_one_cycle", done_a, 1'b0);

        go_a(m_max, v_max, 1'b0);
        wait_done_a(lat, bcnt);
        chk("umax_mv", mv_a, {4{18'd260100}});
        chk("umax_model", mv_ma, {4{18'h3F804}});

        go_a(m_80, v_80, 1'b1);
        wait_done_a(lat, bcnt);
        chk("s80_mv", mv_a, {4{18'd65536}});

        go_a(m_row0, v_ones, 1'b1);
        wait_done_a(lat, bcnt);
        chk("srow0_mv", mv_a, {54'd0, 18'h3FFFC});
        chk("srow0_model", mv_ma, {54'd0, 18'h3FFFC});

        // A start at step 3 is ignored; a start in the done cycle is accepted at once.
        go_a(m_ident, v_4321, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        mat_a = m_80; vec_a = v_80; sm_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        steps = 5;
        while (!done_a && steps < 40) begin
            @(posedge clk); #1;
            steps++;
        end
        chk("hs_first_latency", steps, 8);
        chk("hs_first_mv", mv_a, {18'd4, 18'd3, 18'd2, 18'd1});
        go_a(m_max, v_max, 1'b0);
        wait_done_a(lat, bcnt);
        chk("hs_second_latency", lat, 8);
        chk("hs_second_busy", bcnt, 7);
        chk("hs_second_mv", mv_a, {4{18'd260100}});

        // Reset at step 4 abandons the run.
        go_a(m_80, v_80, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mv", mv_a, '0);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a) saw_done = 1'b1;
        end
        chk("rst_no_done", saw_done, 1'b0);
        go_a(m_ident, v_4321, 1'b0);
        wait_done_a(lat, bcnt);
        chk("rst_fresh_mv", mv_a, {18'd4, 18'd3, 18'd2, 18'd1});
        chk("rst_fresh_latency", lat, 8);

        // Back-to-back random operations on the 8x8 instance.
        go_b();
        for (int i = 0; i < 200; i++) begin
            wait_done_b(lat);
            chk("b_latency", lat, 16);
            if (i < 199) go_b();
        end
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
